mbox_fifo_device: RTL and testbench

- Memory-mapped mailbox responder on the simple-system device bus: host writes push 32-bit words into an internal FIFO, host reads pop them.
- Occupies one 1 kB device window alongside the RAM, simulator-control and timer devices, answering the core's data-port requests.
- Provides status/control registers and a level-triggered threshold interrupt.

---
 rtl/mbox_fifo_device_if.sv | 26 ++
 rtl/mbox_fifo_device.sv | 127 ++++++++++++
 tb/tb_mbox_fifo_device.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mbox_fifo_device_if.sv
// Device-bus bundle between the core data port and the mailbox responder.
// The core side is the master. The mailbox side is the slave.
interface mbox_fifo_device_if #(
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32
);
    logic                    req;
    logic                    we;
    logic [3:0]              be;
    logic [AddressWidth-1:0] addr;
    logic [DataWidth-1:0]    wdata;
    logic                    rvalid;
    logic [DataWidth-1:0]    rdata;
    logic                    err;
    logic                    irq;

    modport master (
        output req, we, be, addr, wdata,
        input  rvalid, rdata, err, irq
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output rvalid, rdata, err, irq
    );
endinterface

// File: rtl/mbox_fifo_device.sv
// Mailbox responder: host writes push into a circular FIFO and host reads pop from it.
// It also has STATUS/CTRL/THRESH registers and a registered level threshold interrupt.
module mbox_fifo_device #(
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32,
    parameter int Depth        = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    mbox_fifo_device_if.slave bus
);
    localparam int PtrW = $clog2(Depth);
    localparam int CntW = PtrW + 1;

    typedef enum logic [1:0] {
        RegData   = 2'd0,
        RegStatus = 2'd1,
        RegCtrl   = 2'd2,
        RegThresh = 2'd3
    } reg_e;

    logic [DataWidth-1:0] mem [Depth];
    logic [PtrW-1:0]      wr_ptr, rd_ptr;
    logic [CntW-1:0]      count;
    logic                 ovf, unf, irq_en;
    logic [8:0]           thresh;

    logic                 rvalid_q, err_q, irq_q;
    logic [DataWidth-1:0] rdata_q;

    logic [7:0]           idx;
    reg_e                 sel;
    logic                 empty, full;
    logic                 acc_err, hit, push_ok, pop_ok;
    logic [31:0]          status;

    assign idx    = bus.addr[9:2];
    assign empty  = (count == '0);
    assign full   = (count == CntW'(Depth));
    assign status = {16'(count), 12'd0, unf, ovf, full, empty};

    // Rejected accesses leave every piece of state untouched, so hit gates all updates.
    always_comb begin
        sel     = reg_e'(idx[1:0]);
        acc_err = 1'b0;
        if (bus.req) begin
            if (|idx[7:2])                                                 acc_err = 1'b1;
            else if (bus.we && (sel == RegData) && (bus.be != 4'hF))      acc_err = 1'b1;
            else if (bus.we && (sel == RegStatus))                         acc_err = 1'b1;
        end
        hit     = bus.req & ~acc_err;
        push_ok = hit &  bus.we & (sel == RegData) & ~full;
        pop_ok  = hit & ~bus.we & (sel == RegData) & ~empty;
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr] <= bus.wdata;
    end

    // irq_q samples registered state, so it follows a count change by one cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            irq_q    <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            unf      <= 1'b0;
            irq_en   <= 1'b0;
            thresh   <= '0;
        end else begin
            rvalid_q <= bus.req;
            err_q    <= acc_err;
            rdata_q  <= '0;
            irq_q    <= irq_en & (thresh != '0) & (9'(count) >= thresh);

            if (push_ok) begin
                wr_ptr <= wr_ptr + PtrW'(1);
                count  <= count + CntW'(1);
            end
            if (pop_ok) begin
                rd_ptr  <= rd_ptr + PtrW'(1);
                count   <= count - CntW'(1);
                rdata_q <= mem[rd_ptr];
            end

            if (hit) begin
                case (sel)
                    RegData: begin
                        if (bus.we && full)   ovf <= 1'b1;
                        if (!bus.we && empty) unf <= 1'b1;
                    end
                    RegStatus: rdata_q <= DataWidth'(status);
                    RegCtrl: begin
                        if (bus.we) begin
                            irq_en <= bus.wdata[0];
                            if (bus.wdata[1]) begin
                                wr_ptr <= '0;
                                rd_ptr <= '0;
                                count  <= '0;
                            end
                            if (bus.wdata[2]) begin
                                ovf <= 1'b0;
                                unf <= 1'b0;
                            end
                        end else begin
                            rdata_q <= DataWidth'(irq_en);
                        end
                    end
                    RegThresh: begin
                        if (bus.we) thresh  <= bus.wdata[8:0];
                        else        rdata_q <= DataWidth'(thresh);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = rdata_q;
    assign bus.err    = err_q;
    assign bus.irq    = irq_q;
endmodule

// File: tb/tb_mbox_fifo_device.sv
// Directed bench for mbox_fifo_device: a response scoreboard plus a queue model of the FIFO.
module tb_mbox_fifo_device;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mbox_fifo_device_if #(.DataWidth(32), .AddressWidth(32)) mbox ();

    mbox_fifo_device #(.DataWidth(32), .AddressWidth(32), .Depth(16)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (mbox.slave)
    );

    int          tests = 0;
    int          fails = 0;
    logic [32:0] sb [$];
    logic [31:0] mdl [$];
    logic        m_ovf = 1'b0;
    logic        m_unf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] status_exp();
        return {16'(mdl.size()), 12'd0, m_unf, m_ovf, mdl.size() == 16, mdl.size() == 0};
    endfunction

    // Called at a negedge; returns at the negedge of the response cycle.
    task automatic access(input logic we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rd,
                          input logic exp_err, input string tag);
        logic [32:0] e;
        sb.push_back({exp_err, exp_rd});
        mbox.req   = 1'b1;
        mbox.we    = we;
        mbox.be    = be;
        mbox.addr  = addr;
        mbox.wdata = wdata;
        @(negedge clk);
        mbox.req   = 1'b0;
        mbox.we    = 1'b0;
        mbox.be    = 4'h0;
        mbox.addr  = '0;
        mbox.wdata = '0;
        chk({tag, ".rvalid"}, 32'(mbox.rvalid), 32'd1);
        e = sb.pop_front();
        chk({tag, ".rdata"}, mbox.rdata, e[31:0]);
        chk({tag, ".err"}, 32'(mbox.err), 32'(e[32]));
    endtask

    task automatic push(input logic [31:0] d);
        if (mdl.size() < 16) mdl.push_back(d);
        else                 m_ovf = 1'b1;
        access(1'b1, 4'hF, 32'h0, d, 32'h0, 1'b0, "push");
    endtask

    task automatic pop(input string tag);
        logic [31:0] exp;
        exp = 32'h0;
        if (mdl.size() > 0) exp = mdl.pop_front();
        else                m_unf = 1'b1;
        access(1'b0, 4'hF, 32'h0, 32'h0, exp, 1'b0, tag);
    endtask

    task automatic rd_status(input string tag);
        access(1'b0, 4'hF, 32'h4, 32'h0, status_exp(), 1'b0, tag);
    endtask

    task automatic wr_ctrl(input logic [31:0] v);
        if (v[2]) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (v[1]) mdl.delete();
        access(1'b1, 4'hF, 32'h8, v, 32'h0, 1'b0, "ctrl_wr");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mbox.req   = 1'b0;
        mbox.we    = 1'b0;
        mbox.be    = 4'h0;
        mbox.addr  = '0;
        mbox.wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst.rvalid", 32'(mbox.rvalid), 32'd0);
        chk("rst.rdata", mbox.rdata, 32'd0);
        chk("rst.err", 32'(mbox.err), 32'd0);
        chk("rst.irq", 32'(mbox.irq), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        access(1'b0, 4'hF, 32'h4, 32'h0, 32'h0000_0001, 1'b0, "status_reset");
        chk("irq_after_reset", 32'(mbox.irq), 32'd0);

        for (int i = 1; i <= 3; i++) push(32'hA5A5_0000 + 32'(i));
        access(1'b0, 4'hF, 32'h4, 32'h0, 32'h0003_0000, 1'b0, "status_three");
        for (int i = 0; i < 3; i++) pop("pop_small");
        access(1'b0, 4'hF, 32'h4, 32'h0, 32'h0000_0001, 1'b0, "status_drained");

        for (int i = 1; i <= 17; i++) push(32'(i));
        access(1'b0, 4'hF, 32'h4, 32'h0, 32'h0010_0006, 1'b0, "status_overflow");
        for (int i = 0; i < 16; i++) pop("pop_full");
        pop("pop_underflow");
        rd_status("status_underflow");
        wr_ctrl(32'h4);
        access(1'b0, 4'hF, 32'h4, 32'h0, 32'h0000_0001, 1'b0, "status_sticky_clr");

        for (int i = 0; i < 40; i++) begin
            push(32'h1234_0000 ^ 32'(i * 7));
            pop("pop_wrap");
        end
        rd_status("status_wrap");

        wr_ctrl(32'h1);
        access(1'b1, 4'hF, 32'hC, 32'h3, 32'h0, 1'b0, "thresh_wr");
        access(1'b0, 4'hF, 32'hC, 32'h0, 32'h3, 1'b0, "thresh_rd");
        push(32'hB0);
        push(32'hB1);
        @(negedge clk);
        chk("irq_two", 32'(mbox.irq), 32'd0);
        push(32'hB2);
        chk("irq_at_rvalid", 32'(mbox.irq), 32'd0);
        @(negedge clk);
        chk("irq_three", 32'(mbox.irq), 32'd1);
        pop("pop_irq");
        @(negedge clk);
        chk("irq_after_pop", 32'(mbox.irq), 32'd0);
        push(32'hB3);
        @(negedge clk);
        chk("irq_again", 32'(mbox.irq), 32'd1);
        wr_ctrl(32'h3);
        @(negedge clk);
        chk("irq_flush", 32'(mbox.irq), 32'd0);
        access(1'b0, 4'h0, 32'h8, 32'h0, 32'h1, 1'b0, "ctrl_rd");
        access(1'b0, 4'hF, 32'h4, 32'h0, 32'h0000_0001, 1'b0, "status_flushed");

        access(1'b1, 4'hF, 32'hC, 32'hFFFF_FFFF, 32'h0, 1'b0, "thresh_wr_all");
        access(1'b0, 4'hF, 32'hC, 32'h0, 32'h0000_01FF, 1'b0, "thresh_rd_mask");
        access(1'b1, 4'hF, 32'hC, 32'h0, 32'h0, 1'b0, "thresh_zero");
        push(32'h55);
        rd_status("status_pre_err");
        access(1'b0, 4'hF, 32'h10, 32'h0, 32'h0, 1'b1, "err_rd_0x10");
        access(1'b1, 4'h3, 32'h0, 32'hDEAD_BEEF, 32'h0, 1'b1, "err_data_be");
        access(1'b1, 4'hF, 32'h4, 32'hFFFF_FFFF, 32'h0, 1'b1, "err_wr_status");
        access(1'b0, 4'hF, 32'h3FC, 32'h0, 32'h0, 1'b1, "err_rd_0x3fc");
        rd_status("status_post_err");
        access(1'b0, 4'h0, 32'h0, 32'h0, 32'h55, 1'b0, "pop_be0");
        void'(mdl.pop_front());
        rd_status("status_be0_pop");

        push(32'h77);
        mbox.req   = 1'b1;
        mbox.we    = 1'b1;
        mbox.be    = 4'hF;
        mbox.addr  = 32'h0;
        mbox.wdata = 32'h99;
        @(posedge clk);
        #2;
        chk("pending_rvalid", 32'(mbox.rvalid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_drop_rvalid", 32'(mbox.rvalid), 32'd0);
        chk("rst_drop_rdata", mbox.rdata, 32'd0);
        mbox.req   = 1'b0;
        mbox.we    = 1'b0;
        mbox.be    = 4'h0;
        mbox.wdata = '0;
        mdl.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        access(1'b0, 4'hF, 32'h4, 32'h0, 32'h0000_0001, 1'b0, "status_after_rst");
        access(1'b0, 4'hF, 32'h8, 32'h0, 32'h0, 1'b0, "ctrl_after_rst");
        chk("irq_after_rst", 32'(mbox.irq), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
